// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: shared state encoding and sizing helpers for the divider.
// Rev 1.0
`default_nettype none

package seq_divider_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_e;

  // Iteration counter must hold WIDTH-1 with headroom for the terminal compare.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_divider_step.sv
// div_step: one restoring shift/compare/subtract iteration on unsigned magnitudes.
// Rev 1.0
`default_nettype none

module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH-1:0] shifted;
  logic [WIDTH:0]   diff;
  logic             borrow;
  // Partial remainder stays below |B| <= 2^(WIDTH-1), so its MSB is always zero.
  logic             unused_rem_msb;

  assign unused_rem_msb = rem_i[WIDTH-1];
  assign shifted        = {rem_i[WIDTH-2:0], quo_i[WIDTH-1]};
  assign diff           = {1'b0, shifted} - {1'b0, divisor_i};
  assign borrow         = diff[WIDTH];
  assign rem_o          = borrow ? shifted : diff[WIDTH-1:0];
  assign quo_o          = {quo_i[WIDTH-2:0], ~borrow};

endmodule

`default_nettype wire

// File: rtl/seq_divider.sv
// seq_divider: iterative signed restoring divider, one quotient bit per clock.
// Rev 1.0
`default_nettype none

module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_resultRDY
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e       state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic             sgnq_q, sgnq_d;
  logic             sgnr_q, sgnr_d;
  logic             special_q, special_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] remout_q, remout_d;
  logic             exc_q, exc_d;
  logic             rdy_q, rdy_d;

  logic [WIDTH-1:0] step_rem, step_quo;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic             is_special;

  assign abs_a      = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign abs_b      = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
  assign is_special = (data_operandB == '0) ||
                      ((data_operandA == MIN_NEG) && (data_operandB == '1));

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (divisor_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    divisor_d = divisor_q;
    sgnq_d    = sgnq_q;
    sgnr_d    = sgnr_q;
    special_d = special_q;
    result_d  = result_q;
    remout_d  = remout_q;
    exc_d     = exc_q;
    rdy_d     = 1'b0;

    case (state_q)
      S_IDLE: ;
      S_RUN: begin
        rem_d   = step_rem;
        quo_d   = step_quo;
        count_d = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        result_d = sgnq_q ? -quo_q : quo_q;
        remout_d = sgnr_q ? -rem_q : rem_q;
        exc_d    = 1'b0;
        rdy_d    = 1'b1;
        state_d  = S_DONE;
      end
      S_DONE: begin
        // A special-case op enters DONE with its result still to publish.
        if (special_q) begin
          result_d  = '0;
          remout_d  = '0;
          exc_d     = 1'b1;
          rdy_d     = 1'b1;
          special_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A new start abandons whatever is in flight without publishing it.
    if (ctrl_DIV) begin
      quo_d     = abs_a;
      rem_d     = '0;
      count_d   = '0;
      divisor_d = abs_b;
      sgnq_d    = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      sgnr_d    = data_operandA[WIDTH-1];
      special_d = is_special;
      result_d  = result_q;
      remout_d  = remout_q;
      exc_d     = exc_q;
      rdy_d     = 1'b0;
      state_d   = is_special ? S_DONE : S_RUN;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      sgnq_q    <= 1'b0;
      sgnr_q    <= 1'b0;
      special_q <= 1'b0;
      result_q  <= '0;
      remout_q  <= '0;
      exc_q     <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      divisor_q <= divisor_d;
      sgnq_q    <= sgnq_d;
      sgnr_q    <= sgnr_d;
      special_q <= special_d;
      result_q  <= result_d;
      remout_q  <= remout_d;
      exc_q     <= exc_d;
      rdy_q     <= rdy_d;
    end
  end

  assign data_result    = result_q;
  assign data_remainder = remout_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed vectors with a scoreboard queue checked by a monitor.
// Rev 1.0
`default_nettype none

module tb_seq_divider;

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] rem;
    logic        exc;
    logic [31:0] edge_no;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic [31:0] data_result;
  logic [31:0] data_remainder;
  logic        data_exception;
  logic        data_resultRDY;

  int   checks = 0;
  int   errors = 0;
  int   edge_cnt = 0;
  bit   prev_rdy = 1'b0;
  exp_t exp_q[$];

  seq_divider #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_remainder (data_remainder),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  always #5 clock = ~clock;

  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  // Monitor: every RDY pulse must match the oldest expected entry.
  always @(negedge clock) begin
    if (data_resultRDY) begin
      checks++;
      if (prev_rdy) begin
        errors++;
        $display("FAIL rdy_width: RDY high on consecutive cycles at edge %0d, required single-cycle", edge_cnt);
      end
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rdy: RDY at edge %0d with nothing outstanding", edge_cnt);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checks += 4;
        if (data_result !== e.res) begin
          errors++;
          $display("FAIL result: got %h, required %h", data_result, e.res);
        end
        if (data_remainder !== e.rem) begin
          errors++;
          $display("FAIL remainder: got %h, required %h", data_remainder, e.rem);
        end
        if (data_exception !== e.exc) begin
          errors++;
          $display("FAIL exception: got %b, required %b", data_exception, e.exc);
        end
        if (edge_cnt != int'(e.edge_no)) begin
          errors++;
          $display("FAIL latency: RDY at edge %0d, required edge %0d", edge_cnt, e.edge_no);
        end
      end
    end
    prev_rdy = data_resultRDY;
  end

  // Called at posedge+#1; the following posedge is the start edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit push,
                       input logic [31:0] er, input logic [31:0] erm, input logic ee,
                       input int lat);
    exp_t e;
    data_operandA = a;
    data_operandB = b;
    ctrl_DIV      = 1'b1;
    if (push) begin
      e.res     = er;
      e.rem     = erm;
      e.exc     = ee;
      e.edge_no = 32'(edge_cnt + 1 + lat);
      exp_q.push_back(e);
    end
    @(posedge clock);
    #1;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 80 && exp_q.size() != 0; i++) @(posedge clock);
    @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL timeout: %0d results outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clock);
    #1;
  endtask

  task automatic check_outputs(input string name, input logic [31:0] r, input logic [31:0] rm,
                               input logic ex, input logic rdy);
    @(negedge clock);
    checks++;
    if (data_result !== r || data_remainder !== rm || data_exception !== ex || data_resultRDY !== rdy) begin
      errors++;
      $display("FAIL %s: got res=%h rem=%h exc=%b rdy=%b, required res=%h rem=%h exc=%b rdy=%b",
               name, data_result, data_remainder, data_exception, data_resultRDY, r, rm, ex, rdy);
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "global timeout");
  end

  initial begin
    repeat (3) @(posedge clock);
    #1;
    check_outputs("reset_state", 32'h0, 32'h0, 1'b0, 1'b0);
    reset_n = 1'b1;

    issue(32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 1'b0, 33);
    wait_done();
    issue(-32'sd100, 32'd7, 1'b1, -32'sd14, -32'sd2, 1'b0, 33);
    wait_done();
    issue(32'd100, -32'sd7, 1'b1, -32'sd14, 32'd2, 1'b0, 33);
    wait_done();
    issue(-32'sd100, -32'sd7, 1'b1, 32'd14, -32'sd2, 1'b0, 33);
    wait_done();

    issue(32'd5, 32'd0, 1'b1, 32'd0, 32'd0, 1'b1, 1);
    wait_done();
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'd0, 1'b1, 1);
    wait_done();

    issue(32'd100, 32'd7, 1'b0, 32'd0, 32'd0, 1'b0, 0);
    repeat (9) @(posedge clock);
    #1;
    issue(32'd9, 32'd3, 1'b1, 32'd3, 32'd0, 1'b0, 33);
    wait_done();

    issue(32'h7FFF_FFFF, 32'd1, 1'b1, 32'h7FFF_FFFF, 32'd0, 1'b0, 33);
    wait_done();
    issue(32'h8000_0000, 32'd2, 1'b1, 32'hC000_0000, 32'd0, 1'b0, 33);
    wait_done();
    issue(32'd7, -32'sd100, 1'b1, 32'd0, 32'd7, 1'b0, 33);
    wait_done();
    issue(32'd3, 32'd10, 1'b1, 32'd0, 32'd3, 1'b0, 33);
    wait_done();
    repeat (4) @(posedge clock);
    #1;
    check_outputs("hold_after_done", 32'd0, 32'd3, 1'b0, 1'b0);

    // Reset after count reaches 10 in RUN: outputs clear and the op never reports.
    issue(32'd100, 32'd7, 1'b0, 32'd0, 32'd0, 1'b0, 0);
    repeat (10) @(posedge clock);
    #1;
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    check_outputs("mid_op_reset", 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (40) @(posedge clock);
    #1;

    // Back-to-back operation after reset still completes normally.
    issue(-32'sd100, 32'd7, 1'b1, -32'sd14, -32'sd2, 1'b0, 33);
    wait_done();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
